// File: rtl/multdiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit:
// FSM states, Booth select codes and operation latencies.
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    BOOTH_ZERO,
    BOOTH_POS1,
    BOOTH_POS2,
    BOOTH_NEG1,
    BOOTH_NEG2
  } booth_code_t;

  // Edges from the start edge to the edge that raises the ready pulse.
  function automatic int mul_latency(input int width);
    return width / 2 + 2;
  endfunction

  function automatic int div_latency(input int width);
    return width + 2;
  endfunction

  function automatic booth_code_t booth_decode(input logic [2:0] window);
    booth_code_t code;
    case (window)
      3'b001, 3'b010: code = BOOTH_POS1;
      3'b011:         code = BOOTH_POS2;
      3'b100:         code = BOOTH_NEG2;
      3'b101, 3'b110: code = BOOTH_NEG1;
      default:        code = BOOTH_ZERO;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/booth4_select.sv
// Radix-4 Booth digit select: turns a 3-bit multiplier window into a
// magnitude (0, M, 2M) plus a negate flag for the shared adder/subtractor.
module booth4_select
  import multdiv_pkg::*;
#(
  parameter int W = 34
) (
  input  logic [2:0]   window,
  input  logic [W-1:0] multiplicand,
  output logic [W-1:0] multiple,
  output logic         negate
);

  booth_code_t code;

  always_comb begin
    code     = booth_decode(window);
    multiple = '0;
    negate   = 1'b0;
    case (code)
      BOOTH_POS1: multiple = multiplicand;
      BOOTH_POS2: multiple = {multiplicand[W-2:0], 1'b0};
      BOOTH_NEG1: begin
        multiple = multiplicand;
        negate   = 1'b1;
      end
      BOOTH_NEG2: begin
        multiple = {multiplicand[W-2:0], 1'b0};
        negate   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multdiv_wide.sv
// Iterative WIDTH x WIDTH multiplier (radix-4 Booth) and divider
// (non-restoring on magnitudes) sharing one WIDTH+2-bit adder/subtractor.
module multdiv_wide
  import multdiv_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit DIV_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             ctrl_signed,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_result_hi,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             data_busy
);

  localparam int W2    = WIDTH + 2;
  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(mul_latency(WIDTH) - 1);
  localparam logic [CNT_W-1:0] DIV_FIX  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(div_latency(WIDTH) - 1);

  state_t state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [W2-1:0]    opa_reg;
  logic [W2-1:0]    acc_reg;
  logic [W2:0]      mq_reg;
  logic             sgn_reg, q_neg_reg, r_neg_reg, div_zero_reg, div_ovf_reg;
  logic [WIDTH-1:0] result_reg, result_hi_reg;
  logic             exception_reg;

  logic div_req;
  logic load_mul, load_div, mul_step, div_step, div_fix, mul_fin, div_fin;

  generate
    if (DIV_EN) begin : g_div
      assign div_req = ctrl_DIV;
    end else begin : g_no_div
      assign div_req = 1'b0;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // A start pulse always wins, which also aborts an operation in flight.
  always_comb begin
    state_next     = state_reg;
    load_mul       = 1'b0;
    load_div       = 1'b0;
    mul_step       = 1'b0;
    div_step       = 1'b0;
    div_fix        = 1'b0;
    mul_fin        = 1'b0;
    div_fin        = 1'b0;
    data_busy      = (state_reg == ST_MUL) || (state_reg == ST_DIV);
    data_resultRDY = (state_reg == ST_DONE);
    if (ctrl_MULT) begin
      state_next = ST_MUL;
      load_mul   = 1'b1;
    end else if (div_req) begin
      state_next = ST_DIV;
      load_div   = 1'b1;
    end else begin
      case (state_reg)
        ST_MUL: begin
          if (cnt_reg == MUL_LAST) begin
            mul_fin    = 1'b1;
            state_next = ST_DONE;
          end else begin
            mul_step = 1'b1;
          end
        end
        ST_DIV: begin
          if (cnt_reg == DIV_LAST) begin
            div_fin    = 1'b1;
            state_next = ST_DONE;
          end else if (cnt_reg == DIV_FIX) begin
            div_fix = 1'b1;
          end else begin
            div_step = 1'b1;
          end
        end
        ST_DONE: state_next = ST_IDLE;
        default: ;
      endcase
    end
  end

  logic [W2-1:0] booth_mult;
  logic          booth_neg;

  booth4_select #(.W(W2)) u_booth (
    .window       (mq_reg[2:0]),
    .multiplicand (opa_reg),
    .multiple     (booth_mult),
    .negate       (booth_neg)
  );

  logic [W2-1:0] add_a, add_b, add_sum;
  logic          add_sub;

  always_comb begin
    add_a   = acc_reg;
    add_b   = booth_mult;
    add_sub = booth_neg;
    if (state_reg == ST_DIV) begin
      add_b = opa_reg;
      if (cnt_reg == DIV_FIX) begin
        add_sub = 1'b0;
      end else begin
        add_a   = {acc_reg[W2-2:0], mq_reg[WIDTH-1]};
        add_sub = ~acc_reg[W2-1];
      end
    end
    add_sum = add_a + (add_b ^ {W2{add_sub}}) + W2'(add_sub);
  end

  logic [2*W2:0]    mul_shifted;
  logic [WIDTH-1:0] mul_lo, mul_hi, a_mag, b_mag, div_q, div_r;
  logic [W2-1:0]    a_ext, b_ext;

  assign mul_shifted = $signed({add_sum, mq_reg}) >>> 2;
  // Product lives in {acc, mq[W2:1]}; mq[0] is the Booth guard bit.
  assign mul_lo = mq_reg[WIDTH:1];
  assign mul_hi = {acc_reg[WIDTH-3:0], mq_reg[W2:WIDTH+1]};
  assign a_ext  = ctrl_signed ? {{2{data_operandA[WIDTH-1]}}, data_operandA} : {2'b00, data_operandA};
  assign b_ext  = ctrl_signed ? {{2{data_operandB[WIDTH-1]}}, data_operandB} : {2'b00, data_operandB};
  assign a_mag  = (ctrl_signed && data_operandA[WIDTH-1]) ? -data_operandA : data_operandA;
  assign b_mag  = (ctrl_signed && data_operandB[WIDTH-1]) ? -data_operandB : data_operandB;
  assign div_q  = mq_reg[WIDTH-1:0];
  assign div_r  = acc_reg[WIDTH-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg       <= '0;
      opa_reg       <= '0;
      acc_reg       <= '0;
      mq_reg        <= '0;
      sgn_reg       <= 1'b0;
      q_neg_reg     <= 1'b0;
      r_neg_reg     <= 1'b0;
      div_zero_reg  <= 1'b0;
      div_ovf_reg   <= 1'b0;
      result_reg    <= '0;
      result_hi_reg <= '0;
      exception_reg <= 1'b0;
    end else begin
      if (load_mul || load_div || !data_busy) cnt_reg <= '0;
      else                                    cnt_reg <= cnt_reg + CNT_W'(1);

      if (load_mul) begin
        sgn_reg <= ctrl_signed;
        opa_reg <= a_ext;
        acc_reg <= '0;
        mq_reg  <= {b_ext, 1'b0};
      end else if (load_div) begin
        sgn_reg      <= ctrl_signed;
        opa_reg      <= {2'b00, b_mag};
        acc_reg      <= '0;
        mq_reg       <= {3'b000, a_mag};
        q_neg_reg    <= ctrl_signed & (data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1]);
        r_neg_reg    <= ctrl_signed & data_operandA[WIDTH-1];
        div_zero_reg <= (data_operandB == '0);
        div_ovf_reg  <= ctrl_signed && (data_operandA == {1'b1, {(WIDTH-1){1'b0}}})
                        && (data_operandB == '1);
      end else if (mul_step) begin
        {acc_reg, mq_reg} <= mul_shifted;
      end else if (div_step) begin
        acc_reg <= add_sum;
        mq_reg  <= {mq_reg[W2:WIDTH], mq_reg[WIDTH-2:0], ~add_sum[W2-1]};
      end else if (div_fix) begin
        if (acc_reg[W2-1]) acc_reg <= add_sum;
      end else if (mul_fin) begin
        result_reg    <= mul_lo;
        result_hi_reg <= mul_hi;
        exception_reg <= sgn_reg ? (mul_hi != {WIDTH{mul_lo[WIDTH-1]}}) : (mul_hi != '0);
      end else if (div_fin) begin
        result_reg    <= div_zero_reg ? '0 : (q_neg_reg ? -div_q : div_q);
        result_hi_reg <= div_zero_reg ? '0 : (r_neg_reg ? -div_r : div_r);
        exception_reg <= div_zero_reg | div_ovf_reg;
      end
    end
  end

  assign data_result    = result_reg;
  assign data_result_hi = result_hi_reg;
  assign data_exception = exception_reg;

endmodule

// File: tb/tb_multdiv_wide.sv
// Directed bench for multdiv_wide at WIDTH=32: latency, results, exceptions,
// abort/restart and reset behaviour against hand-computed values.
module tb_multdiv_wide;

  logic        clock, reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV, ctrl_signed;
  logic [31:0] data_result, data_result_hi;
  logic        data_exception, data_resultRDY, data_busy;

  int tests_run;
  int tests_failed;

  typedef struct packed {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        exc;
  } vec_t;

  multdiv_wide #(.WIDTH(32), .DIV_EN(1'b1)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .ctrl_signed    (ctrl_signed),
    .data_result    (data_result),
    .data_result_hi (data_result_hi),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .data_busy      (data_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Issues one operation and waits (bounded) for the ready pulse.
  // lat = edge index after the start edge at which RDY is seen, -1 if never.
  task automatic do_op(input logic m, input logic d, input logic s,
                       input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int busy_bad);
    @(negedge clock);
    ctrl_MULT = m; ctrl_DIV = d; ctrl_signed = s;
    data_operandA = a; data_operandB = b;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; ctrl_signed = ~s;
    data_operandA = 32'hDEADBEEF; data_operandB = 32'h0BADF00D;
    lat = -1;
    busy_bad = data_busy ? 0 : 1;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(posedge clock); #1;
      if (data_resultRDY) lat = k;
      else if (!data_busy) busy_bad++;
    end
    $display("[TB] %s s=%0d a=%h b=%h -> lat=%0d res=%h hi=%h exc=%0d",
             m ? "MUL" : "DIV", s, a, b, lat, data_result, data_result_hi, data_exception);
  endtask

  task automatic test_reset();
    int rdy_seen;
    reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; ctrl_signed = 1'b0;
    data_operandA = 32'd0; data_operandB = 32'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    ctrl_MULT = 1'b1; data_operandA = 32'd7; data_operandB = 32'd3;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    tests_run++;
    if (data_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_vs_start busy: got %b want 0", data_busy); end
    tests_run++;
    if ({data_result, data_result_hi, data_exception, data_resultRDY} !== 66'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got res=%h hi=%h exc=%b rdy=%b want all 0",
               data_result, data_result_hi, data_exception, data_resultRDY);
    end
    @(negedge clock); reset = 1'b0;
    rdy_seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clock); #1;
      if (data_resultRDY || data_busy) rdy_seen++;
    end
    tests_run++;
    if (rdy_seen !== 0) begin tests_failed++; $display("FAIL reset_no_op: got %0d busy/rdy cycles want 0", rdy_seen); end
    $display("[TB] reset with simultaneous start checked");
  endtask

  task automatic test_mul();
    vec_t v [6];
    int lat, bb;
    v[0] = '{1'b1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0};
    v[1] = '{1'b0, 32'h80000000, 32'd2,        32'h00000000, 32'h00000001, 1'b1};
    v[2] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    v[3] = '{1'b1, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b1};
    v[4] = '{1'b1, 32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 32'h00000000, 1'b1};
    v[5] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b1};
    for (int i = 0; i < 6; i++) begin
      do_op(1'b1, 1'b0, v[i].s, v[i].a, v[i].b, lat, bb);
      tests_run++;
      if (lat !== 18) begin tests_failed++; $display("FAIL mul%0d latency: got %0d want 18", i, lat); end
      tests_run++;
      if (bb !== 0 || data_busy !== 1'b0) begin
        tests_failed++; $display("FAIL mul%0d busy: got %0d gaps, busy_at_rdy=%b want 0,0", i, bb, data_busy);
      end
      tests_run++;
      if ({data_result, data_result_hi, data_exception} !== {v[i].lo, v[i].hi, v[i].exc}) begin
        tests_failed++;
        $display("FAIL mul%0d result: got lo=%h hi=%h exc=%b want lo=%h hi=%h exc=%b",
                 i, data_result, data_result_hi, data_exception, v[i].lo, v[i].hi, v[i].exc);
      end
    end
  endtask

  task automatic test_div();
    vec_t v [9];
    int lat, bb;
    v[0] = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    v[1] = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0};
    v[2] = '{1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'h00000002, 32'hFFFFFFFE, 1'b0};
    v[3] = '{1'b0, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 32'h0000000F, 1'b0};
    v[4] = '{1'b0, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 32'h00000001, 1'b0};
    v[5] = '{1'b0, 32'd5,        32'd0,        32'h00000000, 32'h00000000, 1'b1};
    v[6] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b1};
    v[7] = '{1'b1, 32'h80000000, 32'd1,        32'h80000000, 32'h00000000, 1'b0};
    v[8] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    for (int i = 0; i < 9; i++) begin
      do_op(1'b0, 1'b1, v[i].s, v[i].a, v[i].b, lat, bb);
      tests_run++;
      if (lat !== 34) begin tests_failed++; $display("FAIL div%0d latency: got %0d want 34", i, lat); end
      tests_run++;
      if (bb !== 0 || data_busy !== 1'b0) begin
        tests_failed++; $display("FAIL div%0d busy: got %0d gaps, busy_at_rdy=%b want 0,0", i, bb, data_busy);
      end
      tests_run++;
      if ({data_result, data_result_hi, data_exception} !== {v[i].lo, v[i].hi, v[i].exc}) begin
        tests_failed++;
        $display("FAIL div%0d result: got q=%h r=%h exc=%b want q=%h r=%h exc=%b",
                 i, data_result, data_result_hi, data_exception, v[i].lo, v[i].hi, v[i].exc);
      end
    end
  endtask

  // Pulse width, result hold, start on the DONE cycle, and MULT+DIV priority.
  task automatic test_back_to_back();
    int lat, bb;
    do_op(1'b1, 1'b1, 1'b0, 32'd6, 32'd7, lat, bb);
    tests_run++;
    if (lat !== 18 || data_result !== 32'd42 || data_result_hi !== 32'd0) begin
      tests_failed++;
      $display("FAIL both_ctrl_is_mul: got lat=%0d res=%h hi=%h want 18 0000002a 00000000", lat, data_result, data_result_hi);
    end
    repeat (3) begin
      @(posedge clock); #1;
      tests_run++;
      if (data_resultRDY !== 1'b0 || data_result !== 32'd42 || data_exception !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_after_rdy: got rdy=%b res=%h exc=%b want 0 0000002a 0", data_resultRDY, data_result, data_exception);
      end
    end
    do_op(1'b0, 1'b1, 1'b0, 32'd100, 32'd7, lat, bb);
    do_op(1'b1, 1'b0, 1'b1, 32'hFFFFFFFB, 32'd3, lat, bb);
    tests_run++;
    if (lat !== 18 || bb !== 0 || data_result !== 32'hFFFFFFF1 || data_result_hi !== 32'hFFFFFFFF) begin
      tests_failed++;
      $display("FAIL start_on_done: got lat=%0d gaps=%0d res=%h hi=%h want 18 0 fffffff1 ffffffff",
               lat, bb, data_result, data_result_hi);
    end
  endtask

  task automatic test_abort();
    int rdy_count, first_rdy;
    @(negedge clock);
    ctrl_MULT = 1'b1; ctrl_signed = 1'b0; data_operandA = 32'd9; data_operandB = 32'd9;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    ctrl_DIV = 1'b1; ctrl_signed = 1'b0; data_operandA = 32'd100; data_operandB = 32'd7;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0; data_operandA = 32'h55555555; data_operandB = 32'h0;
    rdy_count = 0; first_rdy = -1;
    for (int k = 6; k <= 60; k++) begin
      @(posedge clock); #1;
      if (data_resultRDY) begin
        rdy_count++;
        if (first_rdy < 0) begin
          first_rdy = k;
          tests_run++;
          if (data_result !== 32'd14 || data_result_hi !== 32'd2 || data_exception !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_result: got q=%h r=%h exc=%b want 0000000e 00000002 0",
                     data_result, data_result_hi, data_exception);
          end
        end
      end
    end
    $display("[TB] abort MUL@0 by DIV 100/7 @5 -> rdy at %0d, %0d pulses", first_rdy, rdy_count);
    tests_run++;
    if (first_rdy !== 39 || rdy_count !== 1) begin
      tests_failed++; $display("FAIL abort_timing: got rdy at %0d x%0d want 39 x1", first_rdy, rdy_count);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bb, bad;
    do_op(1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bb);
    @(negedge clock);
    ctrl_MULT = 1'b1; ctrl_signed = 1'b1; data_operandA = 32'd1234; data_operandB = 32'd5678;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    tests_run++;
    if (data_busy !== 1'b1) begin tests_failed++; $display("FAIL mid_busy_before_reset: got %b want 1", data_busy); end
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0;
    @(posedge clock); #1;
    tests_run++;
    if ({data_busy, data_resultRDY, data_exception, data_result, data_result_hi} !== 67'd0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: got busy=%b rdy=%b exc=%b res=%h hi=%h want all 0",
               data_busy, data_resultRDY, data_exception, data_result, data_result_hi);
    end
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clock); #1;
      if (data_resultRDY || data_busy || data_result != 32'd0) bad++;
    end
    $display("[TB] reset mid-MUL -> %0d active cycles after reset", bad);
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL mid_reset_quiet: got %0d active cycles want 0", bad); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_mul();
    test_div();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
